// File: rtl/ctrl_unit_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM driving datapath selects/enables.
// Define OPCODE_EXC_EN to trap illegal instructions through an EXC state.
module ctrl_unit_fsm #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       iord,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write
`ifdef OPCODE_EXC_EN
   ,
   output logic       exc_opcode
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [2:0] ALU_IDLE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;

   localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT - 1);

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC_R,
      S_RWB,
      S_EXEC_I,
      S_IWB,
      S_BRANCH,
      S_JUMP,
      S_EXC
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] rop_q, rop_d;
   logic       ld_q, ld_d;
   logic       rst_done_q;
   logic       cnt_last;
   logic [2:0] funct_op;
   logic       funct_ok;
   logic       unused_zero;

   // zero gates the PC in the datapath via pc_write_cond, not here
   assign unused_zero = zero;
   assign cnt_last    = (cnt_q == CNT_LAST);

   always_comb begin
      funct_op = ALU_IDLE;
      case (funct)
         6'h20:   funct_op = ALU_ADD;
         6'h22:   funct_op = ALU_SUB;
         6'h24:   funct_op = ALU_AND;
         default: funct_op = ALU_IDLE;
      endcase
   end

   assign funct_ok = (funct_op != ALU_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RESET;
         cnt_q      <= '0;
         rop_q      <= ALU_IDLE;
         ld_q       <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rop_q      <= rop_d;
         ld_q       <= ld_d;
         rst_done_q <= 1'b1;
      end
   end

   // instruction fields are latched in DECODE so later states stay Moore
   always_comb begin
      rop_d = rop_q;
      ld_d  = ld_q;
      if (state_q == S_DECODE) begin
         rop_d = funct_op;
         ld_d  = (opcode == OP_LW);
      end
   end

   always_comb begin
      cnt_d = '0;
      if ((state_d == state_q) &&
          ((state_q == S_FETCH) || (state_q == S_MEMRD)))
         cnt_d = cnt_q + 3'd1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RESET: begin
            // one idle edge after release before the first fetch
            if (rst_done_q)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            if (cnt_last)
               state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
`ifdef OPCODE_EXC_EN
                  state_d = S_EXEC_R;
`else
                  state_d = funct_ok ? S_EXEC_R : S_FETCH;
`endif
               end
               OP_ADDI: state_d = S_EXEC_I;
               OP_LW:   state_d = S_MEMADR;
               OP_SW:   state_d = S_MEMADR;
               OP_BEQ:  state_d = S_BRANCH;
               OP_J:    state_d = S_JUMP;
               default: begin
`ifdef OPCODE_EXC_EN
                  state_d = S_EXC;
`else
                  state_d = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR: state_d = ld_q ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (cnt_last)
               state_d = S_MEMWB;
         end
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = S_FETCH;
         S_EXEC_R: begin
`ifdef OPCODE_EXC_EN
            state_d = funct_ok ? S_RWB : S_EXC;
`else
            state_d = S_RWB;
`endif
         end
         S_RWB:    state_d = S_FETCH;
         S_EXEC_I: state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_EXC:    state_d = S_FETCH;
         default:  state_d = S_RESET;
      endcase
   end

   always_comb begin
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = ALU_IDLE;
      iord          = 1'b0;
      mem_wr        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            if (cnt_last) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
         end
         S_MEMADR, S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            iord   = 1'b1;
            mem_wr = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = rop_q;
         end
         S_RWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            alu_op    = rop_q;
         end
         S_IWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_EXC: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
         end
         default: alu_op = ALU_IDLE;
      endcase
   end

`ifdef OPCODE_EXC_EN
   always_comb exc_opcode = (state_q == S_EXC);
`endif

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Directed bench for ctrl_unit_fsm: MEM_WAIT=2 and MEM_WAIT=3 instances.
// Honours OPCODE_EXC_EN the same way the design does.
module tb_ctrl_unit_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;

   logic       a2, io2, mw2, ir2, pw2, pwc2, rd2, mr2, rw2, x2;
   logic [1:0] b2, ps2;
   logic [2:0] op2;
   logic       a3, io3, mw3, ir3, pw3, pwc3, rd3, mr3, rw3, x3;
   logic [1:0] b3, ps3;
   logic [2:0] op3;

   logic [16:0] o2, o3;
   logic [16:0] exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ctrl_unit_fsm #(.MEM_WAIT(2)) u_dut2 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .alu_src_a(a2), .alu_src_b(b2), .alu_op(op2),
      .iord(io2), .mem_wr(mw2), .ir_write(ir2), .pc_write(pw2),
      .pc_write_cond(pwc2), .pc_source(ps2), .reg_dst(rd2),
      .mem_to_reg(mr2), .reg_write(rw2)
`ifdef OPCODE_EXC_EN
      , .exc_opcode(x2)
`endif
   );

   ctrl_unit_fsm #(.MEM_WAIT(3)) u_dut3 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .alu_src_a(a3), .alu_src_b(b3), .alu_op(op3),
      .iord(io3), .mem_wr(mw3), .ir_write(ir3), .pc_write(pw3),
      .pc_write_cond(pwc3), .pc_source(ps3), .reg_dst(rd3),
      .mem_to_reg(mr3), .reg_write(rw3)
`ifdef OPCODE_EXC_EN
      , .exc_opcode(x3)
`endif
   );

`ifndef OPCODE_EXC_EN
   assign x2 = 1'b0;
   assign x3 = 1'b0;
`endif

   assign o2 = {x2, a2, b2, op2, io2, mw2, ir2, pw2, pwc2, ps2, rd2, mr2, rw2};
   assign o3 = {x3, a3, b3, op3, io3, mw3, ir3, pw3, pwc3, ps3, rd3, mr3, rw3};

   // {exc, a, b, op, iord, mem_wr, ir_wr, pc_wr, pc_wr_cond, pc_src, rd, m2r, rw}
   localparam logic [16:0] E_0    = 17'b0_0_00_000_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_F    = 17'b0_0_01_001_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_FL   = 17'b0_0_01_001_0_0_1_1_0_00_0_0_0;
   localparam logic [16:0] E_DEC  = 17'b0_0_11_001_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_MA   = 17'b0_1_10_001_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_MR   = 17'b0_0_00_000_1_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_MWB  = 17'b0_0_00_000_0_0_0_0_0_00_0_1_1;
   localparam logic [16:0] E_MW   = 17'b0_0_00_000_1_1_0_0_0_00_0_0_0;
   localparam logic [16:0] E_XSUB = 17'b0_1_00_010_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_WSUB = 17'b0_0_00_010_0_0_0_0_0_00_1_0_1;
   localparam logic [16:0] E_XAND = 17'b0_1_00_011_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_WAND = 17'b0_0_00_011_0_0_0_0_0_00_1_0_1;
   localparam logic [16:0] E_XI   = 17'b0_1_10_001_0_0_0_0_0_00_0_0_0;
   localparam logic [16:0] E_IWB  = 17'b0_0_00_000_0_0_0_0_0_00_0_0_1;
   localparam logic [16:0] E_BR   = 17'b0_1_00_010_0_0_0_0_1_01_0_0_0;
   localparam logic [16:0] E_J    = 17'b0_0_00_000_0_0_0_1_0_10_0_0_0;
`ifdef OPCODE_EXC_EN
   localparam logic [16:0] E_EXC  = 17'b1_0_00_000_0_0_0_1_0_11_0_0_0;
   localparam logic [16:0] E_XBAD = 17'b0_1_00_000_0_0_0_0_0_00_0_0_0;
`endif

   task automatic check(input string tag, input logic [16:0] got,
                        input logic [16:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // leaves the bench at the first FETCH cycle of the chosen instance
   task automatic do_reset(input bit sel, input string tag);
      reset = 1'b0;
      repeat (3) step();
      check({tag, ".rst_low"}, sel ? o3 : o2, E_0);
      reset = 1'b1;
      step();
      check({tag, ".rst_edge1"}, sel ? o3 : o2, E_0);
      step();
      check({tag, ".rst_edge2"}, sel ? o3 : o2, E_F);
   endtask

   task automatic run_seq(input bit sel, input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0)
            step();
         check($sformatf("%s[%0d]", tag, i), sel ? o3 : o2, exp_q[i]);
      end
   endtask

   task automatic instr(input bit sel, input string tag,
                        input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
      do_reset(sel, tag);
      run_seq(sel, tag);
   endtask

   initial begin
      #1;
      exp_q = '{E_F, E_FL, E_DEC, E_XSUB, E_WSUB, E_F};
      instr(1'b0, "sub", 6'h00, 6'h22);

      exp_q = '{E_F, E_FL, E_DEC, E_XAND, E_WAND, E_F};
      instr(1'b0, "and", 6'h00, 6'h24);

      exp_q = '{E_F, E_F, E_FL, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MWB, E_F};
      instr(1'b1, "lw_m3", 6'h23, 6'h00);

      exp_q = '{E_F, E_FL, E_DEC, E_MA, E_MR, E_MR, E_MWB, E_F};
      instr(1'b0, "lw_m2", 6'h23, 6'h00);

      exp_q = '{E_F, E_FL, E_DEC, E_BR, E_F};
      zero = 1'b0;
      instr(1'b0, "beq_z0", 6'h04, 6'h00);
      zero = 1'b1;
      instr(1'b0, "beq_z1", 6'h04, 6'h00);
      zero = 1'b0;

      exp_q = '{E_F, E_FL, E_DEC, E_J, E_F};
      instr(1'b0, "j", 6'h02, 6'h00);

      exp_q = '{E_F, E_FL, E_DEC, E_XI, E_IWB, E_F};
      instr(1'b0, "addi", 6'h08, 6'h00);

`ifdef OPCODE_EXC_EN
      exp_q = '{E_F, E_FL, E_DEC, E_EXC, E_F};
      instr(1'b0, "bad_op", 6'h3F, 6'h00);
      exp_q = '{E_F, E_FL, E_DEC, E_XBAD, E_EXC, E_F};
      instr(1'b0, "bad_fn", 6'h00, 6'h3F);
`else
      exp_q = '{E_F, E_FL, E_DEC, E_F, E_FL};
      instr(1'b0, "bad_op", 6'h3F, 6'h00);
      exp_q = '{E_F, E_FL, E_DEC, E_F, E_FL};
      instr(1'b0, "bad_fn", 6'h00, 6'h3F);
`endif

      exp_q = '{E_F, E_FL, E_DEC, E_MA, E_MW};
      instr(1'b0, "sw", 6'h2B, 6'h00);
      reset = 1'b0;
      #1;
      check("sw.async_rst", o2, E_0);
      step();
      check("sw.rst_held", o2, E_0);
      reset = 1'b1;
      step();
      check("sw.rel_edge1", o2, E_0);
      step();
      check("sw.rel_edge2", o2, E_F);
      step();
      check("sw.refetch", o2, E_FL);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
